color_seq_game: RTL and testbench

- Parametrised successor to the fixed 4-colour game FSM.
- Generates a growing pseudo-random colour sequence and plays it back, one colour at a time, with a per-colour buzzer tone.
- Checks the player's colour-sensor inputs against the sequence and tracks score and high score.
- Sits between the colour sensor front end and the LCD controller; `state_o`, `score_o` and `hiscore_o` feed the LCD message mux.

---
 rtl/color_seq_game.sv | 225 ++++++++++++++++++++++
 tb/tb_color_seq_game.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_seq_game.sv
// Colour-sequence memory game: extends a pseudo-random sequence, plays it back with tones and checks the player's echo.
// Optional build macro COLOR_SEQ_SPEEDUP_EN halves show/gap durations once the sequence passes half of MAX_LEN.
module color_seq_game #(
  parameter int          COLOR_W       = 3,
  parameter int          N_COLORS      = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          SHOW_TICKS    = 50,
  parameter int          GAP_TICKS     = 20,
  parameter int          TIMEOUT_TICKS = 1000,
  parameter int          TONE_DIV      = 100,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] color_i,
  input  logic               color_valid_i,
  output logic [COLOR_W-1:0] show_color_o,
  output logic               show_valid_o,
  output logic               buzzer_o,
  output logic [7:0]         score_o,
  output logic [7:0]         hiscore_o,
  output logic [2:0]         state_o,
  output logic               game_over_o,
  output logic               win_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXTEND   = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_GAP = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_CHECK    = 3'd5,
    S_LOSE     = 3'd6,
    S_WIN      = 3'd7
  } state_e;

  localparam int IDX_W    = $clog2(N_COLORS);
  localparam int ADDR_W   = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_MAX  = (SHOW_TICKS > GAP_TICKS)
                            ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                            : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int HALF_MAX = TONE_DIV * ((N_COLORS > 8) ? N_COLORS : 8);
  localparam int CNT_W    = $clog2(HALF_MAX + 1);
  localparam int WIN_HALF = (TONE_DIV / 2 < 1) ? 1 : TONE_DIV / 2;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         pos_q, pos_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [COLOR_W-1:0] cap_q, cap_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         hiscore_q, hiscore_d;
  logic [COLOR_W-1:0] show_color_q, show_color_d;
  logic               buzz_q, buzz_d;
  logic [CNT_W-1:0]   tone_cnt_q, tone_cnt_d;

  logic [IDX_W-1:0]   seq_q [MAX_LEN];
  logic               seq_we;
  logic [IDX_W-1:0]   new_entry;
  logic [IDX_W-1:0]   show_idx;
  logic [COLOR_W-1:0] exp_code;
  logic [TMR_W-1:0]   show_dur, gap_dur;
  logic               tone_on;
  logic [CNT_W-1:0]   half;

`ifdef COLOR_SEQ_SPEEDUP_EN
  localparam int SHOW_FAST = (SHOW_TICKS / 2 < 1) ? 1 : SHOW_TICKS / 2;
  localparam int GAP_FAST  = (GAP_TICKS / 2 < 1) ? 1 : GAP_TICKS / 2;
  logic fast;
  assign fast     = len_q > 8'(MAX_LEN / 2);
  assign show_dur = fast ? TMR_W'(SHOW_FAST) : TMR_W'(SHOW_TICKS);
  assign gap_dur  = fast ? TMR_W'(GAP_FAST)  : TMR_W'(GAP_TICKS);
`else
  assign show_dur = TMR_W'(SHOW_TICKS);
  assign gap_dur  = TMR_W'(GAP_TICKS);
`endif

  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign new_entry = lfsr_q[IDX_W-1:0];
  assign exp_code  = COLOR_W'(seq_q[pos_q[ADDR_W-1:0]]) + COLOR_W'(1);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pos_d     = pos_q;
    timer_d   = '0;
    cap_d     = cap_q;
    score_d   = score_q;
    hiscore_d = hiscore_q;
    seq_we    = 1'b0;

    unique case (state_q)
      S_IDLE, S_LOSE, S_WIN: begin
        if (start) begin
          score_d = '0;
          len_d   = '0;
          state_d = S_EXTEND;
        end
      end
      S_EXTEND: begin
        seq_we  = 1'b1;
        len_d   = len_q + 8'd1;
        pos_d   = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer_q == show_dur - TMR_W'(1)) state_d = S_SHOW_GAP;
        else                                 timer_d = timer_q + TMR_W'(1);
      end
      S_SHOW_GAP: begin
        if (timer_q == gap_dur - TMR_W'(1)) begin
          if (pos_q == len_q - 8'd1) begin
            pos_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            pos_d   = pos_q + 8'd1;
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT_IN: begin
        // A strobe on the last allowed cycle still counts as an answer.
        if (color_valid_i) begin
          cap_d   = color_i;
          state_d = S_CHECK;
        end else if (timer_q == TMR_W'(TIMEOUT_TICKS - 1)) begin
          state_d = S_LOSE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (cap_q != exp_code) begin
          state_d = S_LOSE;
        end else if (pos_q != len_q - 8'd1) begin
          pos_d   = pos_q + 8'd1;
          state_d = S_WAIT_IN;
        end else begin
          score_d   = len_q;
          hiscore_d = (len_q > hiscore_q) ? len_q : hiscore_q;
          state_d   = (len_q == 8'(MAX_LEN)) ? S_WIN : S_EXTEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The entry being written in EXTEND is forwarded so SHOW_ON displays it from its first cycle.
  always_comb begin
    if (seq_we && (pos_d == len_q)) show_idx = new_entry;
    else                            show_idx = seq_q[pos_d[ADDR_W-1:0]];
    show_color_d = (state_d == S_SHOW_ON) ? COLOR_W'(show_idx) + COLOR_W'(1) : '0;
  end

  always_comb begin
    tone_on = 1'b1;
    half    = CNT_W'(WIN_HALF);
    case (state_q)
      S_SHOW_ON: half = CNT_W'(TONE_DIV * int'(show_color_q));
      S_LOSE:    half = CNT_W'(TONE_DIV * 8);
      S_WIN:     half = CNT_W'(WIN_HALF);
      default:   tone_on = 1'b0;
    endcase

    if (!tone_on || (state_d != state_q)) begin
      tone_cnt_d = '0;
      buzz_d     = 1'b0;
    end else if (tone_cnt_q == half - CNT_W'(1)) begin
      tone_cnt_d = '0;
      buzz_d     = ~buzz_q;
    end else begin
      tone_cnt_d = tone_cnt_q + CNT_W'(1);
      buzz_d     = buzz_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      len_q        <= '0;
      pos_q        <= '0;
      timer_q      <= '0;
      cap_q        <= '0;
      score_q      <= '0;
      hiscore_q    <= '0;
      show_color_q <= '0;
      buzz_q       <= 1'b0;
      tone_cnt_q   <= '0;
      // NOTE: the sequence store is small and must read back as zero after reset, so it is cleared here.
      for (int i = 0; i < MAX_LEN; i++) seq_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      len_q        <= len_d;
      pos_q        <= pos_d;
      timer_q      <= timer_d;
      cap_q        <= cap_d;
      score_q      <= score_d;
      hiscore_q    <= hiscore_d;
      show_color_q <= show_color_d;
      buzz_q       <= buzz_d;
      tone_cnt_q   <= tone_cnt_d;
      if (seq_we) seq_q[len_q[ADDR_W-1:0]] <= new_entry;
    end
  end

  assign show_color_o = show_color_q;
  assign show_valid_o = |show_color_q;
  assign buzzer_o     = buzz_q;
  assign score_o      = score_q;
  assign hiscore_o    = hiscore_q;
  assign state_o      = state_q;
  assign game_over_o  = (state_q == S_LOSE);
  assign win_o        = (state_q == S_WIN);

endmodule

// File: tb/tb_color_seq_game.sv
// Self-checking bench for color_seq_game: a reference model predicts each played-back colour and a monitor scores the display.
module tb_color_seq_game;

  localparam int ML = 4;
  localparam int ST = 4;
  localparam int GT = 2;
  localparam int TO = 20;
  localparam int TD = 2;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] color_i = '0;
  logic       color_valid_i = 1'b0;
  logic [2:0] show_color_o;
  logic       show_valid_o;
  logic       buzzer_o;
  logic [7:0] score_o;
  logic [7:0] hiscore_o;
  logic [2:0] state_o;
  logic       game_over_o;
  logic       win_o;

  color_seq_game #(
    .COLOR_W(3), .N_COLORS(NC), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT),
    .TIMEOUT_TICKS(TO), .TONE_DIV(TD), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .color_i(color_i), .color_valid_i(color_valid_i),
    .show_color_o(show_color_o), .show_valid_o(show_valid_o), .buzzer_o(buzzer_o),
    .score_o(score_o), .hiscore_o(hiscore_o), .state_o(state_o),
    .game_over_o(game_over_o), .win_o(win_o)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int dur; } show_t;

  show_t exp_q[$];
  int    m_seq[$];
  int    m_score;
  int    m_hi;
  int    cyc;
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_active = 1'b0;

  // Edges since the last reset edge; the spec LFSR has advanced exactly this many times.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_at(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return int'(l);
  endfunction

  function automatic int show_len(input int len);
`ifdef COLOR_SEQ_SPEEDUP_EN
    if (len > ML / 2) return (ST / 2 < 1) ? 1 : ST / 2;
`endif
    return ST + 0 * len;
  endfunction

  function automatic int gap_len(input int len);
`ifdef COLOR_SEQ_SPEEDUP_EN
    if (len > ML / 2) return (GT / 2 < 1) ? 1 : GT / 2;
`endif
    return GT + 0 * len;
  endfunction

  // Monitor: each display episode pops one expectation and checks colour, tone and duration.
  initial begin
    show_t cur;
    int    run;
    bit    in_show;
    cur.code = 0; cur.dur = 0; run = 0; in_show = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_active) begin
        in_show = 1'b0;
        run = 0;
      end else if (show_valid_o === 1'b1) begin
        if (!in_show) begin
          in_show = 1'b1;
          run = 0;
          if (exp_q.size() == 0) begin
            cur.code = 0; cur.dur = 0;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        check("show_color", int'(show_color_o), cur.code);
        check("show_buzzer", int'(buzzer_o), (cur.code == 0) ? 0 : (run / (TD * cur.code)) % 2);
        run++;
      end else if (in_show) begin
        in_show = 1'b0;
        check("show_cycles", run, cur.dur);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state_o), 0);
    check({tag, "_show_color"}, int'(show_color_o), 0);
    check({tag, "_show_valid"}, int'(show_valid_o), 0);
    check({tag, "_buzzer"}, int'(buzzer_o), 0);
    check({tag, "_score"}, int'(score_o), 0);
    check({tag, "_hiscore"}, int'(hiscore_o), 0);
    check({tag, "_game_over"}, int'(game_over_o), 0);
    check({tag, "_win"}, int'(win_o), 0);
  endtask

  task automatic do_reset();
    mon_active = 1'b0;
    exp_q.delete();
    m_seq.delete();
    m_score = 0;
    m_hi = 0;
    start = 1'b0;
    color_valid_i = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_active = 1'b1;
  endtask

  // Called at the negedge where the DUT is in EXTEND; returns at the first WAIT_IN negedge.
  task automatic extend_round();
    int    n, len, expected;
    show_t e;
    check("extend_state", int'(state_o), 1);
    m_seq.push_back(lfsr_at(cyc) % NC);
    len = m_seq.size();
    foreach (m_seq[i]) begin
      e.code = m_seq[i] + 1;
      e.dur  = show_len(len);
      exp_q.push_back(e);
    end
    expected = len * (show_len(len) + gap_len(len)) + 1;
    n = 0;
    while (state_o != 3'd4 && n < 200) begin
      // Input noise during playback must be ignored.
      color_valid_i = 1'($urandom_range(0, 1));
      color_i       = 3'($urandom_range(0, 7));
      start         = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    color_valid_i = 1'b0;
    start = 1'b0;
    check("wait_in_latency", n, expected);
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_seq.delete();
    m_score = 0;
    check("restart_score", int'(score_o), 0);
    extend_round();
  endtask

  task automatic answer(input int code);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    color_i = 3'(code);
    color_valid_i = 1'b1;
    @(negedge clk);
    color_valid_i = 1'b0;
    check("check_state", int'(state_o), 5);
  endtask

  // Echo the current round; optionally get the last colour wrong.
  task automatic play_round(input bit fail_last);
    int len, code;
    len = m_seq.size();
    for (int i = 0; i < len; i++) begin
      code = m_seq[i] + 1;
      if (fail_last && i == len - 1) code = (m_seq[i] + 1) % NC + 1;
      answer(code);
      @(negedge clk);
      if (fail_last && i == len - 1) begin
        check("lose_state", int'(state_o), 6);
        check("lose_game_over", int'(game_over_o), 1);
        check("lose_score", int'(score_o), m_score);
      end else if (i < len - 1) begin
        check("next_wait_state", int'(state_o), 4);
      end else begin
        m_score = len;
        if (len > m_hi) m_hi = len;
        check("round_score", int'(score_o), m_score);
        check("round_hiscore", int'(hiscore_o), m_hi);
        if (len == ML) begin
          check("win_state", int'(state_o), 7);
          check("win_flag", int'(win_o), 1);
        end else begin
          extend_round();
        end
      end
    end
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    repeat (10) @(negedge clk);
    check_all_zero("idle");

    // Full game to WIN, then the WIN tone toggles every TONE_DIV/2 cycles.
    start_game();
    for (int r = 0; r < ML; r++) play_round(1'b0);
    for (int k = 0; k < 8; k++) begin
      check("win_buzzer", int'(buzzer_o), (k / (TD / 2)) % 2);
      @(negedge clk);
    end

    // Wrong colour in round 1; LOSE tone half-period is TONE_DIV*8.
    start_game();
    play_round(1'b1);
    check("lose_hiscore_kept", int'(hiscore_o), 4);
    for (int k = 0; k < 40; k++) begin
      check("lose_buzzer", int'(buzzer_o), (k / (TD * 8)) % 2);
      @(negedge clk);
    end

    // Timeout: LOSE exactly TIMEOUT_TICKS cycles after WAIT_IN entry.
    start_game();
    repeat (TO - 1) @(negedge clk);
    check("timeout_last_wait", int'(state_o), 4);
    @(negedge clk);
    check("timeout_lose", int'(state_o), 6);

    // Strobe on the final allowed cycle is accepted.
    start_game();
    repeat (TO - 1) @(negedge clk);
    color_i = 3'(m_seq[0] + 1);
    color_valid_i = 1'b1;
    @(negedge clk);
    color_valid_i = 1'b0;
    check("late_strobe_check", int'(state_o), 5);
    @(negedge clk);
    m_score = 1;
    check("late_strobe_score", int'(score_o), 1);
    extend_round();
    play_round(1'b0);
    play_round(1'b1);

    // High score tracking across games after a fresh reset.
    do_reset();
    start_game();
    play_round(1'b0);
    play_round(1'b0);
    play_round(1'b1);
    start_game();
    play_round(1'b0);
    play_round(1'b1);
    check("hiscore_best", int'(hiscore_o), 2);
    check("score_last", int'(score_o), 1);

    // Reset in the middle of SHOW_ON.
    mon_active = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_show_state", int'(state_o), 2);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
